// File: rtl/reaction_stats_if.sv
// Purpose: bundles the trial input, history read port and statistics outputs of reaction_stats.
// Latency: none, wires only.
// Backpressure: none; the producer watches busy/overrun, and trials arriving while busy are dropped.
interface reaction_stats_if #(
    parameter int DEPTH = 8,
    parameter int RES_W = 9,
    parameter int CNT_W = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             clear;
    logic             trial_done;
    logic [1:0]       trial_code;
    logic [RES_W-1:0] trial_ms;
    logic [PTR_W-1:0] rd_idx;
    logic [RES_W-1:0] rd_data;
    logic [PTR_W:0]   hist_count;
    logic [RES_W-1:0] best_ms;
    logic [RES_W-1:0] worst_ms;
    logic [RES_W-1:0] avg_ms;
    logic             avg_valid;
    logic [CNT_W-1:0] legal_cnt;
    logic [CNT_W-1:0] early_cnt;
    logic [CNT_W-1:0] late_cnt;
    logic             new_best;
    logic             busy;
    logic             overrun;

    // Producer side: the tester and the bus wrapper.
    modport master (
        output clear, trial_done, trial_code, trial_ms, rd_idx,
        input  rd_data, hist_count, best_ms, worst_ms, avg_ms, avg_valid,
               legal_cnt, early_cnt, late_cnt, new_best, busy, overrun
    );

    // Statistics block side.
    modport slave (
        input  clear, trial_done, trial_code, trial_ms, rd_idx,
        output rd_data, hist_count, best_ms, worst_ms, avg_ms, avg_valid,
               legal_cnt, early_cnt, late_cnt, new_best, busy, overrun
    );
endinterface

// File: rtl/reaction_stats.sv
// Purpose: per-trial statistics - history ring, best/worst, saturating counters, windowed average.
// Latency: stats 1 cycle after trial_done; avg_ms 1+SUM_W cycles; rd_data 1 cycle after rd_idx.
// Backpressure: none; busy is high while dividing, and a trial_done during busy is dropped and sets overrun.
module reaction_stats #(
    parameter int DEPTH = 8,
    parameter int RES_W = 9,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rstn,
    reaction_stats_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int HC_W  = PTR_W + 1;
    localparam int SUM_W = RES_W + PTR_W;
    localparam int DC_W  = $clog2(SUM_W + 1);

    typedef enum logic {IDLE, DIV} state_t;

    state_t           state_q, state_d;

    logic [RES_W-1:0] hist_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [HC_W-1:0]  hist_count_q, hist_count_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    logic [RES_W-1:0] best_q, worst_q, avg_q, rd_data_q;
    logic             avg_valid_q, new_best_q, overrun_q;
    logic [CNT_W-1:0] legal_cnt_q, early_cnt_q, late_cnt_q;

    // Divider: dvd_q shifts the dividend out at the top and the quotient in at the bottom.
    logic [SUM_W-1:0] dvd_q, dvd_d;
    logic [HC_W-1:0]  dvs_q;
    logic [HC_W-1:0]  rem_q, rem_d;
    logic [DC_W-1:0]  div_cnt_q;
    logic [HC_W:0]    rem_sh;
    logic             rem_ge;

    logic             take, accept_legal, accept_early, accept_late, drop;
    logic             full, first, div_last;
    logic [PTR_W-1:0] rd_addr;
    logic             rd_hit;

    // A trial is only looked at when clear is idle; clear swallows a coincident trial.
    assign take         = bus.trial_done && !bus.clear;
    assign accept_legal = take && (state_q == IDLE) && (bus.trial_code == 2'b00);
    assign accept_early = take && (state_q == IDLE) && (bus.trial_code == 2'b01);
    assign accept_late  = take && (state_q == IDLE) && (bus.trial_code == 2'b10);
    assign drop         = take && (state_q == DIV);

    assign full     = (hist_count_q == HC_W'(DEPTH));
    assign first    = (hist_count_q == '0);
    assign div_last = (state_q == DIV) && (div_cnt_q == DC_W'(SUM_W - 1));

    assign hist_count_d = full ? hist_count_q : hist_count_q + HC_W'(1);
    // Window sum: add the newcomer, retire the entry it overwrites once the ring is full.
    assign sum_d = sum_q + SUM_W'(bus.trial_ms) - (full ? SUM_W'(hist_q[wr_ptr_q]) : '0);

    // rem stays below the divisor, so the subtraction fits in HC_W bits modulo wrap.
    assign rem_sh = {rem_q, dvd_q[SUM_W-1]};
    assign rem_ge = (rem_sh >= {1'b0, dvs_q});
    assign rem_d  = rem_sh[HC_W-1:0] - (rem_ge ? dvs_q : '0);
    assign dvd_d  = {dvd_q[SUM_W-2:0], rem_ge};

    // rd_idx 0 is the newest entry, i.e. the one just behind the write pointer.
    assign rd_addr = wr_ptr_q - PTR_W'(1) - bus.rd_idx;
    assign rd_hit  = ({1'b0, bus.rd_idx} < hist_count_q);

    // Next-state: IDLE waits for a legal trial, DIV runs a fixed SUM_W cycles.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept_legal) state_d = DIV;
                DIV:     if (div_last)     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // History ring, write pointer, valid count and window sum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            wr_ptr_q     <= '0;
            hist_count_q <= '0;
            sum_q        <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            wr_ptr_q     <= '0;
            hist_count_q <= '0;
            sum_q        <= '0;
        end else if (accept_legal) begin
            hist_q[wr_ptr_q] <= bus.trial_ms;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            hist_count_q     <= hist_count_d;
            sum_q            <= sum_d;
        end
    end

    // Best/worst tracking, saturating trial counters, new_best pulse and sticky overrun.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            best_q      <= '0;
            worst_q     <= '0;
            legal_cnt_q <= '0;
            early_cnt_q <= '0;
            late_cnt_q  <= '0;
            new_best_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (bus.clear) begin
            best_q      <= '0;
            worst_q     <= '0;
            legal_cnt_q <= '0;
            early_cnt_q <= '0;
            late_cnt_q  <= '0;
            new_best_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            new_best_q <= 1'b0;
            if (drop) overrun_q <= 1'b1;
            if (accept_legal) begin
                if (legal_cnt_q != '1) legal_cnt_q <= legal_cnt_q + CNT_W'(1);
                if (first || (bus.trial_ms < best_q)) begin
                    best_q     <= bus.trial_ms;
                    new_best_q <= 1'b1;
                end
                if (first || (bus.trial_ms > worst_q)) worst_q <= bus.trial_ms;
            end
            if (accept_early && (early_cnt_q != '1)) early_cnt_q <= early_cnt_q + CNT_W'(1);
            if (accept_late  && (late_cnt_q  != '1)) late_cnt_q  <= late_cnt_q  + CNT_W'(1);
        end
    end

    // Restoring divider: operands latched on entry, one quotient bit per DIV cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            div_cnt_q   <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else if (bus.clear) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            div_cnt_q   <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else if (accept_legal) begin
            dvd_q     <= sum_d;
            dvs_q     <= hist_count_d;
            rem_q     <= '0;
            div_cnt_q <= '0;
        end else if (state_q == DIV) begin
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            div_cnt_q <= div_cnt_q + DC_W'(1);
            if (div_last) begin
                avg_q       <= dvd_d[RES_W-1:0];
                avg_valid_q <= 1'b1;
            end
        end
    end

    // Registered history read; entries beyond the valid count read as zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          rd_data_q <= '0;
        else if (bus.clear) rd_data_q <= '0;
        else                rd_data_q <= rd_hit ? hist_q[rd_addr] : '0;
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.hist_count = hist_count_q;
    assign bus.best_ms    = best_q;
    assign bus.worst_ms   = worst_q;
    assign bus.avg_ms     = avg_q;
    assign bus.avg_valid  = avg_valid_q;
    assign bus.legal_cnt  = legal_cnt_q;
    assign bus.early_cnt  = early_cnt_q;
    assign bus.late_cnt   = late_cnt_q;
    assign bus.new_best   = new_best_q;
    assign bus.busy       = (state_q == DIV);
    assign bus.overrun    = overrun_q;
endmodule
